// File: rtl/multiexp_pnt_scl_serdes.sv
// Multi-exponentiation front end: serializes (scalar, affine point) pairs into core frames
// with Z words appended, and packs core result words into wide result beats.
module multiexp_pnt_scl_serdes #(
    parameter int                  DAT_BITS       = 256,
    parameter int                  COORD_WORDS    = 4,
    parameter int                  PNT_BEAT_WORDS = 2,
    parameter int                  RES_BEAT_WORDS = 2,
    parameter logic [DAT_BITS-1:0] CONST_ONE      = {{(DAT_BITS-1){1'b0}}, 1'b1}
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_start,
    input  logic [63:0]                        i_num_in,
    output logic                               o_busy,
    input  logic [DAT_BITS-1:0]                i_scl_dat,
    input  logic                               i_scl_val,
    output logic                               o_scl_rdy,
    input  logic [PNT_BEAT_WORDS*DAT_BITS-1:0] i_pnt_dat,
    input  logic                               i_pnt_val,
    output logic                               o_pnt_rdy,
    output logic [DAT_BITS-1:0]                o_ser_dat,
    output logic                               o_ser_val,
    output logic                               o_ser_sop,
    output logic                               o_ser_eop,
    output logic                               o_ser_last,
    input  logic                               i_ser_rdy,
    input  logic [DAT_BITS-1:0]                i_core_dat,
    input  logic                               i_core_val,
    output logic                               o_core_rdy,
    output logic [RES_BEAT_WORDS*DAT_BITS-1:0] o_res_dat,
    output logic                               o_res_val,
    output logic                               o_res_sop,
    output logic                               o_res_eop,
    input  logic                               i_res_rdy
);

    localparam int RES_WORDS = 3 * COORD_WORDS / 2;
    localparam int ZED_WORDS = COORD_WORDS / 2;
    localparam int CW_W      = (COORD_WORDS > 1)    ? $clog2(COORD_WORDS)    : 1;
    localparam int PB_W      = (PNT_BEAT_WORDS > 1) ? $clog2(PNT_BEAT_WORDS) : 1;
    localparam int ZW_W      = (ZED_WORDS > 1)      ? $clog2(ZED_WORDS)      : 1;
    localparam int RW_W      = (RES_WORDS > 1)      ? $clog2(RES_WORDS)      : 1;
    localparam int RB_W      = (RES_BEAT_WORDS > 1) ? $clog2(RES_BEAT_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCL  = 2'd1,
        PNT  = 2'd2,
        ZED  = 2'd3
    } state_t;

    state_t            r_state;
    logic [63:0]       r_num;
    logic [63:0]       r_pnt_cnt;
    logic [CW_W-1:0]   r_word;
    logic [PB_W-1:0]   r_beat;
    logic [ZW_W-1:0]   r_zed;
    logic              r_nz;
    logic              r_inf;
    logic [RW_W-1:0]   r_res_w;
    logic [RB_W-1:0]   r_slot;

    logic                w_ld_en;
    logic [DAT_BITS-1:0] w_pnt_word;
    logic                w_beat_end;
    logic                w_last_pnt;
    logic                w_zed_end;
    logic                w_core_acc;

    assign w_ld_en    = ~o_ser_val | i_ser_rdy;
    assign w_pnt_word = i_pnt_dat[int'(r_beat)*DAT_BITS +: DAT_BITS];
    assign w_beat_end = (r_beat == PB_W'(PNT_BEAT_WORDS-1));
    assign w_last_pnt = (r_pnt_cnt == (r_num - 64'd1));
    assign w_zed_end  = (r_zed == ZW_W'(ZED_WORDS-1));

    assign o_busy     = (r_state != IDLE);
    assign o_scl_rdy  = (r_state == SCL) & w_ld_en;
    // A point beat is only released once its last word is being loaded.
    assign o_pnt_rdy  = (r_state == PNT) & w_ld_en & i_pnt_val & w_beat_end;
    assign o_core_rdy = i_rst_n & (~o_res_val | i_res_rdy);
    assign w_core_acc = i_core_val & o_core_rdy;

    // Serializer: scalar, affine words, then Z words per point.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_num      <= 64'd0;
            r_pnt_cnt  <= 64'd0;
            r_word     <= '0;
            r_beat     <= '0;
            r_zed      <= '0;
            r_nz       <= 1'b0;
            r_inf      <= 1'b0;
            o_ser_dat  <= '0;
            o_ser_val  <= 1'b0;
            o_ser_sop  <= 1'b0;
            o_ser_eop  <= 1'b0;
            o_ser_last <= 1'b0;
        end else begin
            if (i_ser_rdy) begin
                o_ser_val <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (i_start && (i_num_in != 64'd0)) begin
                        r_num     <= i_num_in;
                        r_pnt_cnt <= 64'd0;
                        r_state   <= SCL;
                    end
                end
                SCL: begin
                    if (w_ld_en && i_scl_val) begin
                        o_ser_dat  <= i_scl_dat;
                        o_ser_val  <= 1'b1;
                        o_ser_sop  <= 1'b1;
                        o_ser_eop  <= 1'b0;
                        o_ser_last <= 1'b0;
                        r_word     <= '0;
                        r_beat     <= '0;
                        r_nz       <= 1'b0;
                        r_state    <= PNT;
                    end
                end
                PNT: begin
                    if (w_ld_en && i_pnt_val) begin
                        o_ser_dat  <= w_pnt_word;
                        o_ser_val  <= 1'b1;
                        o_ser_sop  <= 1'b0;
                        o_ser_eop  <= 1'b0;
                        o_ser_last <= 1'b0;
                        r_beat     <= w_beat_end ? '0 : r_beat + PB_W'(1);
                        // Infinity is decided including the final affine word.
                        if (r_word == CW_W'(COORD_WORDS-1)) begin
                            r_inf   <= ~(r_nz | (|w_pnt_word));
                            r_zed   <= '0;
                            r_state <= ZED;
                        end else begin
                            r_word  <= r_word + CW_W'(1);
                            r_nz    <= r_nz | (|w_pnt_word);
                        end
                    end
                end
                ZED: begin
                    if (w_ld_en) begin
                        o_ser_dat  <= ((r_zed == '0) && !r_inf) ? CONST_ONE : '0;
                        o_ser_val  <= 1'b1;
                        o_ser_sop  <= 1'b0;
                        o_ser_eop  <= w_zed_end;
                        o_ser_last <= w_zed_end & w_last_pnt;
                        if (w_zed_end) begin
                            if (w_last_pnt) begin
                                r_state <= IDLE;
                            end else begin
                                r_pnt_cnt <= r_pnt_cnt + 64'd1;
                                r_state   <= SCL;
                            end
                        end else begin
                            r_zed <= r_zed + ZW_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Deserializer: pack core words into result beats, low slot first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res_w   <= '0;
            r_slot    <= '0;
            o_res_dat <= '0;
            o_res_val <= 1'b0;
            o_res_sop <= 1'b0;
            o_res_eop <= 1'b0;
        end else begin
            if (i_res_rdy) begin
                o_res_val <= 1'b0;
            end
            if (w_core_acc) begin
                o_res_dat[int'(r_slot)*DAT_BITS +: DAT_BITS] <= i_core_dat;
                if (r_slot == RB_W'(RES_BEAT_WORDS-1)) begin
                    o_res_val <= 1'b1;
                    o_res_sop <= (r_res_w == RW_W'(RES_BEAT_WORDS-1));
                    o_res_eop <= (r_res_w == RW_W'(RES_WORDS-1));
                    r_slot    <= '0;
                end else begin
                    r_slot    <= r_slot + RB_W'(1);
                end
                r_res_w <= (r_res_w == RW_W'(RES_WORDS-1)) ? '0 : r_res_w + RW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multiexp_pnt_scl_serdes.sv
// Scoreboard bench for multiexp_pnt_scl_serdes with G2 defaults.
module tb_multiexp_pnt_scl_serdes;

    localparam int DB  = 256;
    localparam int PBW = 2;
    localparam int RBW = 2;

    logic               clk = 1'b0;
    logic               i_rst_n, i_start;
    logic [63:0]        i_num_in;
    logic               o_busy;
    logic [DB-1:0]      i_scl_dat;
    logic               i_scl_val, o_scl_rdy;
    logic [PBW*DB-1:0]  i_pnt_dat;
    logic               i_pnt_val, o_pnt_rdy;
    logic [DB-1:0]      o_ser_dat;
    logic               o_ser_val, o_ser_sop, o_ser_eop, o_ser_last, i_ser_rdy;
    logic [DB-1:0]      i_core_dat;
    logic               i_core_val, o_core_rdy;
    logic [RBW*DB-1:0]  o_res_dat;
    logic               o_res_val, o_res_sop, o_res_eop, i_res_rdy;

    typedef struct { logic [DB-1:0] dat; logic sop; logic eop; logic last; } ser_t;
    typedef struct { logic [RBW*DB-1:0] dat; logic sop; logic eop; } res_t;

    ser_t              ser_exp[$];
    res_t              res_exp[$];
    logic [DB-1:0]     scl_q[$];
    logic [PBW*DB-1:0] pnt_q[$];
    logic [DB-1:0]     core_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int ser_cnt  = 0;
    int pnt_fires = 0;
    int res_hold = 0;
    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;

    multiexp_pnt_scl_serdes dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_num_in(i_num_in), .o_busy(o_busy),
        .i_scl_dat(i_scl_dat), .i_scl_val(i_scl_val), .o_scl_rdy(o_scl_rdy),
        .i_pnt_dat(i_pnt_dat), .i_pnt_val(i_pnt_val), .o_pnt_rdy(o_pnt_rdy),
        .o_ser_dat(o_ser_dat), .o_ser_val(o_ser_val), .o_ser_sop(o_ser_sop),
        .o_ser_eop(o_ser_eop), .o_ser_last(o_ser_last), .i_ser_rdy(i_ser_rdy),
        .i_core_dat(i_core_dat), .i_core_val(i_core_val), .o_core_rdy(o_core_rdy),
        .o_res_dat(o_res_dat), .o_res_val(o_res_val), .o_res_sop(o_res_sop),
        .o_res_eop(o_res_eop), .i_res_rdy(i_res_rdy)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DB-1:0] rnd_word();
        logic [DB-1:0] w;
        for (int i = 0; i < DB/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // mode 0: random point, 1: all-zero point, 2: only the last affine word nonzero
    task automatic push_point(input int mode, input bit last);
        logic [DB-1:0] s, w[4];
        s = rnd_word();
        for (int k = 0; k < 4; k++) w[k] = (mode == 0) ? rnd_word() : '0;
        if (mode == 2) w[3] = rnd_word() | {{(DB-1){1'b0}}, 1'b1};
        scl_q.push_back(s);
        pnt_q.push_back({w[1], w[0]});
        pnt_q.push_back({w[3], w[2]});
        ser_exp.push_back('{s, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < 4; k++) ser_exp.push_back('{w[k], 1'b0, 1'b0, 1'b0});
        ser_exp.push_back('{(mode == 1) ? '0 : DB'(1), 1'b0, 1'b0, 1'b0});
        ser_exp.push_back('{'0, 1'b0, 1'b1, last});
    endtask

    task automatic push_result();
        logic [DB-1:0] w[6];
        for (int k = 0; k < 6; k++) begin
            w[k] = rnd_word();
            core_q.push_back(w[k]);
        end
        res_exp.push_back('{{w[1], w[0]}, 1'b1, 1'b0});
        res_exp.push_back('{{w[3], w[2]}, 1'b0, 1'b0});
        res_exp.push_back('{{w[5], w[4]}, 1'b0, 1'b1});
    endtask

    task automatic start_job(input logic [63:0] n);
        @(posedge clk); #2;
        i_start  = 1'b1;
        i_num_in = n;
        @(posedge clk); #2;
        i_start  = 1'b0;
        i_num_in = 64'd0;
    endtask

    task automatic wait_job(input string tag);
        for (int c = 0; c < 4000 && (o_busy || ser_exp.size() != 0); c++) @(negedge clk);
        check({tag, "_done"}, {o_busy, 1'(ser_exp.size() == 0)}, 2'b01);
    endtask

    task automatic wait_res(input string tag);
        for (int c = 0; c < 500 && (res_exp.size() != 0 || core_q.size() != 0); c++) @(negedge clk);
        check({tag, "_done"}, {1'(res_exp.size() == 0), 1'(core_q.size() == 0)}, 2'b11);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {o_ser_val, o_ser_sop, o_ser_eop, o_ser_last, o_busy, o_scl_rdy,
              o_pnt_rdy, o_core_rdy, o_res_val, o_res_sop, o_res_eop}, 11'd0);
        check({tag, "_ser_dat"}, o_ser_dat, '0);
        check({tag, "_res_dat"}, o_res_dat, '0);
    endtask

    // Monitor at negedge, drive sources just after posedge.
    initial begin
        ser_t e;
        res_t r;
        bit   scl_f, pnt_f, core_f;
        forever begin
            @(negedge clk);
            scl_f  = i_scl_val && o_scl_rdy;
            pnt_f  = i_pnt_val && o_pnt_rdy;
            core_f = i_core_val && o_core_rdy;
            if (pnt_f) pnt_fires++;
            if (o_ser_val && i_ser_rdy) begin
                ser_cnt++;
                if (ser_exp.size() == 0) begin
                    check("ser_extra", o_ser_val, 1'b0);
                end else begin
                    e = ser_exp.pop_front();
                    check("ser_dat", o_ser_dat, e.dat);
                    check("ser_flags", {o_ser_sop, o_ser_eop, o_ser_last}, {e.sop, e.eop, e.last});
                end
            end
            if (o_res_val && i_res_rdy) begin
                if (res_exp.size() == 0) begin
                    check("res_extra", o_res_val, 1'b0);
                end else begin
                    r = res_exp.pop_front();
                    check("res_dat", o_res_dat, r.dat);
                    check("res_flags", {o_res_sop, o_res_eop}, {r.sop, r.eop});
                end
            end
            @(posedge clk); #1;
            if (scl_f && scl_q.size() > 0) void'(scl_q.pop_front());
            if (pnt_f && pnt_q.size() > 0) void'(pnt_q.pop_front());
            if (core_f && core_q.size() > 0) void'(core_q.pop_front());
            i_scl_val  = (scl_q.size() > 0);
            i_scl_dat  = (scl_q.size() > 0) ? scl_q[0] : '0;
            i_pnt_val  = (pnt_q.size() > 0);
            i_pnt_dat  = (pnt_q.size() > 0) ? pnt_q[0] : '0;
            i_core_val = (core_q.size() > 0);
            i_core_dat = (core_q.size() > 0) ? core_q[0] : '0;
            i_ser_rdy  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            i_res_rdy  = (res_hold == 0);
            if (res_hold > 0) res_hold--;
        end
    end

    initial begin
        int base;
        i_rst_n = 1'b0; i_start = 1'b0; i_num_in = 64'd0;
        i_scl_dat = '0; i_scl_val = 1'b0; i_pnt_dat = '0; i_pnt_val = 1'b0;
        i_ser_rdy = 1'b1; i_core_dat = '0; i_core_val = 1'b0; i_res_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #2;
        i_rst_n = 1'b1;

        // two G2 frames at full rate
        push_point(0, 1'b0);
        push_point(0, 1'b1);
        start_job(64'd2);
        @(negedge clk);
        check("busy_on", o_busy, 1'b1);
        wait_job("job2");

        // infinity and near-infinity points
        push_point(1, 1'b0);
        push_point(2, 1'b0);
        push_point(1, 1'b1);
        start_job(64'd3);
        wait_job("inf");

        // random output backpressure over 16 points
        rand_rdy  = 1'b1;
        pnt_fires = 0;
        for (int p = 0; p < 16; p++) push_point(0, p == 15);
        start_job(64'd16);
        wait_job("rand16");
        rand_rdy = 1'b0;
        check("pnt_beats", pnt_fires, 32);

        // ignored starts: zero count, and start while busy
        base = ser_cnt;
        start_job(64'd0);
        repeat (10) @(negedge clk);
        check("zero_start", {o_busy, 1'(ser_cnt == base)}, 2'b01);
        push_point(0, 1'b0);
        push_point(0, 1'b1);
        start_job(64'd2);
        repeat (3) @(posedge clk);
        start_job(64'd5);
        wait_job("busy_start");
        repeat (10) @(negedge clk);
        check("busy_start_idle", {o_busy, 1'(ser_cnt == base + 14)}, 2'b01);

        // deserializer with result backpressure
        res_hold = 6;
        push_result();
        push_result();
        wait_res("res12");

        // reset mid-frame and mid-result
        push_point(0, 1'b0);
        push_point(0, 1'b1);
        core_q.push_back(rnd_word());
        base = ser_cnt;
        start_job(64'd2);
        for (int c = 0; c < 200 && ser_cnt < base + 3; c++) @(negedge clk);
        check("pre_rst_words", 1'(ser_cnt >= base + 3), 1'b1);
        @(posedge clk); #2;
        i_rst_n = 1'b0;
        scl_q.delete(); pnt_q.delete(); core_q.delete();
        ser_exp.delete(); res_exp.delete();
        @(negedge clk);
        check_quiet("mid_rst");
        repeat (2) @(negedge clk);
        check_quiet("mid_rst2");
        @(posedge clk); #2;
        i_rst_n = 1'b1;
        push_point(0, 1'b1);
        start_job(64'd1);
        wait_job("post_rst");
        push_result();
        wait_res("post_rst_res");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
